// File: rtl/bitty_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// bitty_fetch_ctrl
//
// Instruction-fetch controller for the Bitty core. Each fetch is a serial
// transaction over a byte-wide UART pair: one address byte out, then two
// instruction bytes back (high byte first). Each response byte has its own
// timeout. A timed-out transaction is resent from the address byte, up to
// MAX_RETRY times, after which a one-cycle error pulse is raised.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   fetch_req    CPU fetch request, sampled only in IDLE
//   fetch_addr   instruction address, latched when fetch_req is accepted
//   instr        last fetched instruction, held until the next good fetch
//   instr_valid  one-cycle pulse: instr was just updated
//   fetch_err    one-cycle pulse: fetch abandoned after all retries
//   busy         high whenever the FSM is not in IDLE
//   tx_data      byte to the UART transmitter (always the latched address)
//   tx_start     one-cycle transmit strobe
//   tx_busy      transmitter occupied
//   rx_data      byte from the UART receiver
//   rx_valid     one-cycle pulse: rx_data is valid
//   dbg_state    current FSM state, for debug/observation
//
// Handshakes: tx_start is a strobe that fires only while tx_busy is low, so
// a byte is handed over in exactly the cycle tx_start=1. rx_valid is a
// single-cycle pulse with no back-pressure; a byte is consumed only in
// RX_HI/RX_LO and silently dropped in every other state. fetch_req is a
// level sampled in IDLE only; it is neither queued nor acknowledged other
// than through instr_valid / fetch_err.
// -----------------------------------------------------------------------------
module bitty_fetch_ctrl #(
  parameter int TIMEOUT   = 1023,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [7:0]  fetch_addr,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [2:0]  dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_RX_HI = 3'd2,
    S_RX_LO = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t         state;
  logic [7:0]     addr_q;
  logic [7:0]     hi_q;
  logic [TW-1:0]  timer;
  logic [RW-1:0]  retry_cnt;
  logic           timeout_hit;
  logic           retry_ok;

  // Timer counts from 0 on entry to an RX state, so hitting TIMEOUT-1 with
  // no byte means TIMEOUT cycles have elapsed in that state.
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign retry_ok    = (retry_cnt < RW'(MAX_RETRY));

  assign tx_start  = (state == S_SEND) && !tx_busy;
  assign busy      = (state != S_IDLE);
  assign tx_data   = addr_q;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      hi_q        <= '0;
      timer       <= '0;
      retry_cnt   <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (fetch_req) begin
            addr_q    <= fetch_addr;
            retry_cnt <= '0;
            state     <= S_SEND;
          end
        end

        // Waiting on a busy transmitter is not a link stall, so the timer
        // stays parked here.
        S_SEND: begin
          timer <= '0;
          if (!tx_busy) state <= S_RX_HI;
        end

        // rx_valid is checked before the timeout so a byte landing on the
        // last cycle of the window is still accepted.
        S_RX_HI: begin
          if (rx_valid) begin
            hi_q  <= rx_data;
            timer <= '0;
            state <= S_RX_LO;
          end else if (timeout_hit) begin
            timer <= '0;
            hi_q  <= '0;
            if (retry_ok) begin
              retry_cnt <= retry_cnt + RW'(1);
              state     <= S_SEND;
            end else begin
              state <= S_ERR;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_RX_LO: begin
          if (rx_valid) begin
            instr       <= {hi_q, rx_data};
            instr_valid <= 1'b1;
            timer       <= '0;
            state       <= S_IDLE;
          end else if (timeout_hit) begin
            timer <= '0;
            hi_q  <= '0;
            if (retry_ok) begin
              retry_cnt <= retry_cnt + RW'(1);
              state     <= S_SEND;
            end else begin
              state <= S_ERR;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        // fetch_err lands in the first IDLE cycle, so busy is already low
        // while the pulse is visible.
        S_ERR: begin
          fetch_err <= 1'b1;
          timer     <= '0;
          state     <= S_IDLE;
        end

        default: begin
          timer <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitty_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bitty_fetch_ctrl
//
// Directed bench for bitty_fetch_ctrl (TIMEOUT=8, MAX_RETRY=3). The driver
// pushes the expected response ({err, instr}) into exp_q when it issues a
// fetch; a negedge monitor pops and compares whenever instr_valid or
// fetch_err is seen, and also checks every tx_start byte and counts them.
// Inputs change 1 time unit after the rising edge; cycle-exact checks in the
// driver are taken 2 units after the edge.
// -----------------------------------------------------------------------------
module tb_bitty_fetch_ctrl;

  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 3;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic        fetch_err;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [2:0]  dbg_state;

  int          tests  = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          tx_cnt = 0;
  logic [7:0]  exp_tx = 8'h00;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;
  int          t0;
  int          start_cyc;

  bitty_fetch_ctrl #(
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .instr      (instr),
    .instr_valid(instr_valid),
    .fetch_err  (fetch_err),
    .busy       (busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request before an edge; returns in cycle 1 (SEND).
  task automatic issue(input logic [7:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    exp_tx     = a;
    step();
    fetch_req  = 1'b0;
    fetch_addr = 8'h00;
  endtask

  // Drives one response byte for a single cycle.
  task automatic rx_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) begin
        tx_cnt++;
        check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx});
      end
      if (instr_valid || fetch_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {14'h0, fetch_err, instr_valid, instr}, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp", {14'h0, fetch_err, instr_valid, instr},
                {14'h0, mon_e[16], ~mon_e[16], mon_e[15:0]});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = 8'h00;
    tx_busy    = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr",    {16'h0, instr}, 32'h0);
    check("rst_valid",    {31'h0, instr_valid}, 32'h0);
    check("rst_err",      {31'h0, fetch_err}, 32'h0);
    check("rst_busy",     {31'h0, busy}, 32'h0);
    check("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check("rst_state",    {29'h0, dbg_state}, 32'h0);
    reset = 1'b0;
    step();

    // Basic fetch: bytes in cycles 2 and 3, instr_valid in cycle 4.
    exp_q.push_back({1'b0, 16'h1234});
    issue(8'h2A);
    settle();
    check("basic_tx_start", {31'h0, tx_start}, 32'h1);
    check("basic_busy",     {31'h0, busy}, 32'h1);
    step();
    rx_byte(8'h12);
    rx_byte(8'h34);
    settle();
    check("basic_valid", {31'h0, instr_valid}, 32'h1);
    check("basic_instr", {16'h0, instr}, 32'h1234);
    check("basic_busy_low", {31'h0, busy}, 32'h0);
    step();

    // TX back-pressure: no strobe and no timeout while tx_busy holds.
    exp_q.push_back({1'b0, 16'hBEEF});
    tx_busy = 1'b1;
    issue(8'h3C);
    for (int i = 0; i < 10; i++) begin
      settle();
      check("bp_tx_low", {31'h0, tx_start}, 32'h0);
      step();
    end
    check("bp_still_busy", {31'h0, busy}, 32'h1);
    check("bp_no_err", {31'h0, fetch_err}, 32'h0);
    tx_busy = 1'b0;
    settle();
    check("bp_tx_start", {31'h0, tx_start}, 32'h1);
    step();
    rx_byte(8'hBE);
    rx_byte(8'hEF);
    settle();
    check("bp_instr", {16'h0, instr}, 32'hBEEF);
    step();

    // Single retry: second strobe exactly 9 cycles after the first.
    exp_q.push_back({1'b0, 16'hABCD});
    issue(8'h2A);
    settle();
    check("retry_first_tx", {31'h0, tx_start}, 32'h1);
    repeat (8) step();
    settle();
    check("retry_not_early", {31'h0, tx_start}, 32'h0);
    step();
    settle();
    check("retry_second_tx", {31'h0, tx_start}, 32'h1);
    step();
    rx_byte(8'hAB);
    rx_byte(8'hCD);
    settle();
    check("retry_valid", {31'h0, instr_valid}, 32'h1);
    check("retry_instr", {16'h0, instr}, 32'hABCD);
    step();

    // Boundary: both bytes land when timer == TIMEOUT-1; a request raised
    // mid-transaction is ignored.
    t0 = tx_cnt;
    exp_q.push_back({1'b0, 16'h5AA5});
    issue(8'h11);
    step();
    for (int i = 0; i < 7; i++) begin
      fetch_req  = (i == 3);
      fetch_addr = (i == 3) ? 8'h99 : 8'h00;
      step();
    end
    fetch_req  = 1'b0;
    fetch_addr = 8'h00;
    rx_byte(8'h5A);
    settle();
    check("bnd_hi_no_retry", {31'h0, tx_start}, 32'h0);
    check("bnd_hi_busy", {31'h0, busy}, 32'h1);
    repeat (7) step();
    rx_byte(8'hA5);
    settle();
    check("bnd_valid", {31'h0, instr_valid}, 32'h1);
    check("bnd_instr", {16'h0, instr}, 32'h5AA5);
    check("busy_req_ignored", tx_cnt - t0, 32'd1);
    check("busy_req_addr", {24'h0, tx_data}, 32'h11);
    step();

    // Retry exhaustion: 4 strobes, fetch_err in cycle 38, instr kept.
    t0 = tx_cnt;
    exp_q.push_back({1'b1, 16'h5AA5});
    issue(8'h77);
    start_cyc = cyc;
    for (int i = 0; i < 60; i++) begin
      settle();
      if (fetch_err) break;
      step();
    end
    check("err_latency", cyc - start_cyc, 32'd37);
    check("err_tx_count", tx_cnt - t0, 32'd4);
    check("err_instr_kept", {16'h0, instr}, 32'h5AA5);
    check("err_busy_low", {31'h0, busy}, 32'h0);
    check("err_no_valid", {31'h0, instr_valid}, 32'h0);
    step();
    settle();
    check("err_one_cycle", {31'h0, fetch_err}, 32'h0);

    // Reset mid-fetch in RX_LO; late byte dropped; fresh fetch works.
    issue(8'h42);
    step();
    rx_byte(8'h55);
    reset = 1'b1;
    settle();
    check("mid_rst_instr", {16'h0, instr}, 32'h0);
    check("mid_rst_busy",  {31'h0, busy}, 32'h0);
    check("mid_rst_tx",    {31'h0, tx_start}, 32'h0);
    check("mid_rst_txd",   {24'h0, tx_data}, 32'h0);
    check("mid_rst_flags", {30'h0, instr_valid, fetch_err}, 32'h0);
    step();
    reset = 1'b0;
    step();
    rx_byte(8'h66);
    settle();
    check("late_byte_busy",  {31'h0, busy}, 32'h0);
    check("late_byte_instr", {16'h0, instr}, 32'h0);
    step();
    exp_q.push_back({1'b0, 16'h1357});
    issue(8'h42);
    step();
    rx_byte(8'h13);
    rx_byte(8'h57);
    settle();
    check("post_rst_instr", {16'h0, instr}, 32'h1357);

    repeat (3) step();
    check("sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
